// File: rtl/nrisc_firq_ctrl.sv
// Fast-interrupt sequencer for the NRISC core: stalls at an instruction boundary,
// saves the return PC, vectors to the serviced source and swaps in the FIRQ register bank.
`ifndef TAM
`define TAM 16
`endif

module nrisc_firq_ctrl #(
  parameter int unsigned        TAM      = `TAM,
  parameter int unsigned        NIRQ     = 4,
  parameter logic [TAM-1:0]     VEC_BASE = TAM'(16'h0010)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] irq_in,
  input  logic            irq_en_we,
  input  logic [NIRQ-1:0] irq_en_d,
  input  logic [TAM-1:0]  core_pc,
  input  logic            core_stall_ack,
  input  logic            reti,
  output logic            core_stall_req,
  output logic            redirect,
  output logic [TAM-1:0]  redirect_pc,
  output logic            bank_sel,
  output logic            irq_active,
  output logic [2:0]      irq_id,
  output logic [TAM-1:0]  epc,
  output logic [NIRQ-1:0] irq_pend
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRAIN  = 3'd1;
  localparam logic [2:0] S_ENTER  = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_EXIT   = 3'd4;

  logic [2:0]      state;
  logic [NIRQ-1:0] en;
  logic [2:0]      pend_id;
  logic [TAM-1:0]  vec_pc;

  assign irq_pend = irq_in & en;

  // Fixed priority: scanning from the top down lets the lowest set index win.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pend_id = 3'd0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (irq_pend[i]) pend_id = 3'(i);
    end
  end

  assign vec_pc = VEC_BASE + TAM'({pend_id, 2'b00});

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state          <= S_IDLE;
      en             <= '0;
      core_stall_req <= 1'b0;
      redirect       <= 1'b0;
      redirect_pc    <= '0;
      bank_sel       <= 1'b0;
      irq_active     <= 1'b0;
      irq_id         <= 3'd0;
      epc            <= '0;
    end else begin
      if (irq_en_we) en <= irq_en_d;

      case (state)
        S_IDLE: begin
          if (|irq_pend) begin
            state          <= S_DRAIN;
            core_stall_req <= 1'b1;
          end
        end

        // A withdrawn or masked request aborts the entry even if the core acks now.
        S_DRAIN: begin
          if (~|irq_pend) begin
            state          <= S_IDLE;
            core_stall_req <= 1'b0;
          end else if (core_stall_ack) begin
            state       <= S_ENTER;
            epc         <= core_pc;
            irq_id      <= pend_id;
            redirect    <= 1'b1;
            redirect_pc <= vec_pc;
            bank_sel    <= 1'b1;
            irq_active  <= 1'b1;
          end
        end

        S_ENTER: begin
          state          <= S_ACTIVE;
          redirect       <= 1'b0;
          core_stall_req <= 1'b0;
        end

        // No nesting: new requests wait until the handler has returned.
        S_ACTIVE: begin
          if (reti) begin
            state       <= S_EXIT;
            redirect    <= 1'b1;
            redirect_pc <= epc;
          end
        end

        S_EXIT: begin
          state      <= S_IDLE;
          redirect   <= 1'b0;
          bank_sel   <= 1'b0;
          irq_active <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nrisc_firq_ctrl.sv
// Self-checking bench for nrisc_firq_ctrl: a per-cycle vector table covering entry,
// exit, abort and priority, plus hand sequences for masking and mid-handler reset.
module tb_nrisc_firq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq_in;
  logic        irq_en_we;
  logic [3:0]  irq_en_d;
  logic [15:0] core_pc;
  logic        core_stall_ack;
  logic        reti;
  logic        core_stall_req;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        bank_sel;
  logic        irq_active;
  logic [2:0]  irq_id;
  logic [15:0] epc;
  logic [3:0]  irq_pend;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  nrisc_firq_ctrl #(.TAM(16), .NIRQ(4), .VEC_BASE(16'h0010)) dut (
    .clk           (clk),
    .rst           (rst),
    .irq_in        (irq_in),
    .irq_en_we     (irq_en_we),
    .irq_en_d      (irq_en_d),
    .core_pc       (core_pc),
    .core_stall_ack(core_stall_ack),
    .reti          (reti),
    .core_stall_req(core_stall_req),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .bank_sel      (bank_sel),
    .irq_active    (irq_active),
    .irq_id        (irq_id),
    .epc           (epc),
    .irq_pend      (irq_pend)
  );

  // Inputs for one cycle; pend is checked before the edge, the rest just after it.
  typedef struct {
    logic [3:0]  irq;
    logic        we;
    logic [3:0]  en_d;
    logic [15:0] pc;
    logic        ack;
    logic        reti;
    logic [3:0]  pend;
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic        bank;
    logic        act;
    logic [2:0]  id;
    logic [15:0] epc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] irq, input logic we, input logic [3:0] en_d,
                       input logic [15:0] pc, input logic ack, input logic r);
    irq_in         = irq;
    irq_en_we      = we;
    irq_en_d       = en_d;
    core_pc        = pc;
    core_stall_ack = ack;
    reti           = r;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".stall"}, 32'(core_stall_req), 32'd0);
    check({tag, ".redir"}, 32'(redirect),       32'd0);
    check({tag, ".rpc"},   32'(redirect_pc),    32'd0);
    check({tag, ".bank"},  32'(bank_sel),       32'd0);
    check({tag, ".act"},   32'(irq_active),     32'd0);
    check({tag, ".id"},    32'(irq_id),         32'd0);
    check({tag, ".epc"},   32'(epc),            32'd0);
  endtask

  initial begin
    //              irq      we    en_d     pc        ack   reti  | pend     stall redir rpc       bank  act   id    epc
    // Entry on source 1 with only it enabled, then return.
    vecs.push_back('{4'b0010, 1'b1, 4'b0010, 16'h0123, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000});
    vecs.push_back('{4'b0010, 1'b0, 4'b0000, 16'h0123, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000});
    vecs.push_back('{4'b0010, 1'b0, 4'b0000, 16'h0123, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1, 16'h0014, 1'b1, 1'b1, 3'd1, 16'h0123});
    vecs.push_back('{4'b0010, 1'b0, 4'b0000, 16'h0123, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, 16'h0014, 1'b1, 1'b1, 3'd1, 16'h0123});
    vecs.push_back('{4'b0000, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0014, 1'b1, 1'b1, 3'd1, 16'h0123});
    vecs.push_back('{4'b0000, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 16'h0123, 1'b1, 1'b1, 3'd1, 16'h0123});
    vecs.push_back('{4'b0000, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0123, 1'b0, 1'b0, 3'd1, 16'h0123});
    // Two requests, all enabled: source 1 wins; requests and reti-in-EXIT ignored.
    vecs.push_back('{4'b1010, 1'b1, 4'b1111, 16'h0000, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 16'h0123, 1'b0, 1'b0, 3'd1, 16'h0123});
    vecs.push_back('{4'b1010, 1'b0, 4'b0000, 16'h0200, 1'b1, 1'b0, 4'b1010, 1'b1, 1'b1, 16'h0014, 1'b1, 1'b1, 3'd1, 16'h0200});
    vecs.push_back('{4'b1010, 1'b0, 4'b0000, 16'h0200, 1'b1, 1'b0, 4'b1010, 1'b0, 1'b0, 16'h0014, 1'b1, 1'b1, 3'd1, 16'h0200});
    vecs.push_back('{4'b1010, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 4'b1010, 1'b0, 1'b0, 16'h0014, 1'b1, 1'b1, 3'd1, 16'h0200});
    vecs.push_back('{4'b0001, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 16'h0014, 1'b1, 1'b1, 3'd1, 16'h0200});
    vecs.push_back('{4'b0000, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 16'h0200, 1'b1, 1'b1, 3'd1, 16'h0200});
    vecs.push_back('{4'b0000, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 16'h0200, 1'b0, 1'b0, 3'd1, 16'h0200});
    // reti in IDLE ignored.
    vecs.push_back('{4'b0000, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 16'h0200, 1'b0, 1'b0, 3'd1, 16'h0200});
    // reti in DRAIN ignored, then request withdrawn: abort.
    vecs.push_back('{4'b0100, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 16'h0200, 1'b0, 1'b0, 3'd1, 16'h0200});
    vecs.push_back('{4'b0100, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b0, 16'h0200, 1'b0, 1'b0, 3'd1, 16'h0200});
    vecs.push_back('{4'b0000, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0200, 1'b0, 1'b0, 3'd1, 16'h0200});
    // Withdrawal in the same cycle as ack: abort wins.
    vecs.push_back('{4'b1000, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 16'h0200, 1'b0, 1'b0, 3'd1, 16'h0200});
    vecs.push_back('{4'b0000, 1'b0, 4'b0000, 16'h0777, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0200, 1'b0, 1'b0, 3'd1, 16'h0200});
    // Masked off while draining: abort even with ack.
    vecs.push_back('{4'b1000, 1'b1, 4'b0111, 16'h0000, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 16'h0200, 1'b0, 1'b0, 3'd1, 16'h0200});
    vecs.push_back('{4'b1000, 1'b0, 4'b0000, 16'h0999, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0200, 1'b0, 1'b0, 3'd1, 16'h0200});
    // Source 2, then back-to-back service of source 0 (DRAIN at reti+3).
    vecs.push_back('{4'b0100, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 16'h0200, 1'b0, 1'b0, 3'd1, 16'h0200});
    vecs.push_back('{4'b0100, 1'b0, 4'b0000, 16'h0456, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b1, 16'h0018, 1'b1, 1'b1, 3'd2, 16'h0456});
    vecs.push_back('{4'b0100, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 16'h0018, 1'b1, 1'b1, 3'd2, 16'h0456});
    vecs.push_back('{4'b0001, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b1, 16'h0456, 1'b1, 1'b1, 3'd2, 16'h0456});
    vecs.push_back('{4'b0001, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 16'h0456, 1'b0, 1'b0, 3'd2, 16'h0456});
    vecs.push_back('{4'b0001, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 16'h0456, 1'b0, 1'b0, 3'd2, 16'h0456});
    vecs.push_back('{4'b0001, 1'b0, 4'b0000, 16'h0789, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b1, 16'h0010, 1'b1, 1'b1, 3'd0, 16'h0789});
    vecs.push_back('{4'b0001, 1'b0, 4'b0000, 16'h0789, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 16'h0010, 1'b1, 1'b1, 3'd0, 16'h0789});
    vecs.push_back('{4'b0000, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 16'h0789, 1'b1, 1'b1, 3'd0, 16'h0789});
    vecs.push_back('{4'b0000, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0789, 1'b0, 1'b0, 3'd0, 16'h0789});
    // Highest source, left in ACTIVE for the reset sequence below.
    vecs.push_back('{4'b1000, 1'b1, 4'b1000, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0789, 1'b0, 1'b0, 3'd0, 16'h0789});
    vecs.push_back('{4'b1000, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 16'h0789, 1'b0, 1'b0, 3'd0, 16'h0789});
    vecs.push_back('{4'b1000, 1'b0, 4'b0000, 16'h0abc, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b1, 16'h001c, 1'b1, 1'b1, 3'd3, 16'h0abc});
    vecs.push_back('{4'b1000, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 16'h001c, 1'b1, 1'b1, 3'd3, 16'h0abc});

    // Reset and check the reset state.
    rst = 1'b1;
    drive(4'b0000, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    drive(4'b1111, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0);
    #1;
    check("reset.pend_masked", 32'(irq_pend), 32'd0);
    @(negedge clk);
    irq_in = 4'b0000;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].irq, vecs[i].we, vecs[i].en_d, vecs[i].pc, vecs[i].ack, vecs[i].reti);
      #1;
      check($sformatf("v%0d.pend", i), 32'(irq_pend), 32'(vecs[i].pend));
      @(posedge clk);
      #1;
      check($sformatf("v%0d.stall", i), 32'(core_stall_req), 32'(vecs[i].stall));
      check($sformatf("v%0d.redir", i), 32'(redirect),       32'(vecs[i].redir));
      check($sformatf("v%0d.rpc", i),   32'(redirect_pc),    32'(vecs[i].rpc));
      check($sformatf("v%0d.bank", i),  32'(bank_sel),       32'(vecs[i].bank));
      check($sformatf("v%0d.act", i),   32'(irq_active),     32'(vecs[i].act));
      check($sformatf("v%0d.id", i),    32'(irq_id),         32'(vecs[i].id));
      check($sformatf("v%0d.epc", i),   32'(epc),            32'(vecs[i].epc));
    end

    // Reset while ACTIVE: bank drops without a redirect, mask cleared.
    @(negedge clk);
    rst = 1'b1;
    drive(4'b1111, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_idle_outputs("rst_active");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_active.pend", 32'(irq_pend), 32'd0);
    @(posedge clk);
    #1;
    check("rst_active.no_stall", 32'(core_stall_req), 32'd0);

    // Masked request: no stall for 10 cycles, then enable and expect stall 2 cycles later.
    @(negedge clk);
    drive(4'b0001, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("masked.c%0d.stall", c), 32'(core_stall_req), 32'd0);
    end
    @(negedge clk);
    irq_en_we = 1'b1;
    irq_en_d  = 4'b0001;
    @(posedge clk);
    #1;
    check("enable.stall_w1", 32'(core_stall_req), 32'd0);
    @(negedge clk);
    irq_en_we = 1'b0;
    irq_en_d  = 4'b0000;
    #1;
    check("enable.pend", 32'(irq_pend), 32'h1);
    @(posedge clk);
    #1;
    check("enable.stall_w2", 32'(core_stall_req), 32'd1);
    check("enable.no_redir", 32'(redirect), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
